// File: rtl/door_lock_actuator_if.sv
// Signal bundle between the code-detector side and the door lock actuator.
// The master drives the requests and the raw door contact.
// The slave (the actuator) drives the solenoid, state and status flags.
interface door_lock_actuator_if;
    logic       unlock_req;
    logic       lock_cmd;
    logic       door_open;
    logic       solenoid_en;
    logic [1:0] state_o;
    logic       alarm;
    logic       tamper;
    logic [7:0] event_count;

    modport master (
        output unlock_req,
        output lock_cmd,
        output door_open,
        input  solenoid_en,
        input  state_o,
        input  alarm,
        input  tamper,
        input  event_count
    );

    modport slave (
        input  unlock_req,
        input  lock_cmd,
        input  door_open,
        output solenoid_en,
        output state_o,
        output alarm,
        output tamper,
        output event_count
    );
endinterface

// File: rtl/door_lock_actuator.sv
// Door lock actuator: consumes the code detector's unlock pulse, drives the
// bolt solenoid, follows the door through a synchronized contact, times the
// unlock window and the relock settle period, and flags held-open / tamper.
// Optional macro DOOR_EVENT_CNT_EN builds a saturating granted-unlock counter;
// without it event_count is tied to zero.
module door_lock_actuator #(
    parameter int unsigned UNLOCK_CYCLES = 20,
    parameter int unsigned HOLD_CYCLES   = 50,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    door_lock_actuator_if.slave  bus
);

    localparam int unsigned MAX_UH     = (UNLOCK_CYCLES > HOLD_CYCLES) ? UNLOCK_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_UH > SETTLE_CYCLES) ? MAX_UH : SETTLE_CYCLES;
    localparam int unsigned TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_UNLOCKED = 2'd1,
        S_OPEN     = 2'd2,
        S_RELOCK   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            timer_restart;
    logic            sync1_q, door_s_q;
    logic            sol_q, sol_d;
    logic            alarm_q, alarm_d;
    logic            tamper_q, tamper_d;

    // Two-flop synchronizer for the asynchronous door contact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            door_s_q <= 1'b0;
        end else begin
            sync1_q  <= bus.door_open;
            door_s_q <= sync1_q;
        end
    end

    // State, shared timer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_LOCKED;
            timer_q  <= '0;
            sol_q    <= 1'b0;
            alarm_q  <= 1'b0;
            tamper_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sol_q    <= sol_d;
            alarm_q  <= alarm_d;
            tamper_q <= tamper_d;
        end
    end

    // Next-state, timer and next-output logic.
    always_comb begin
        state_d       = state_q;
        timer_restart = 1'b0;
        alarm_d       = 1'b0;
        tamper_d      = tamper_q;

        case (state_q)
            S_LOCKED: begin
                // A simultaneous unlock takes priority over the tamper flag.
                if (bus.unlock_req) begin
                    state_d = S_UNLOCKED;
                end else if (door_s_q) begin
                    tamper_d = 1'b1;
                end
            end
            S_UNLOCKED: begin
                if (door_s_q) begin
                    state_d = S_OPEN;
                end else if (bus.lock_cmd) begin
                    state_d = S_LOCKED;
                end else if (bus.unlock_req) begin
                    timer_restart = 1'b1;
                end else if (timer_q == UNLOCK_LAST) begin
                    state_d = S_LOCKED;
                end
            end
            S_OPEN: begin
                if (!door_s_q) begin
                    state_d = S_RELOCK;
                end else begin
                    alarm_d = alarm_q || (timer_q == HOLD_LAST);
                end
            end
            S_RELOCK: begin
                if (door_s_q) begin
                    state_d = S_OPEN;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = S_LOCKED;
                end
            end
            default: begin
                state_d = S_LOCKED;
            end
        endcase

        sol_d = (state_d != S_LOCKED);

        // Timer clears on any state change or window restart, else saturates.
        if ((state_d != state_q) || timer_restart) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

`ifdef DOOR_EVENT_CNT_EN
    logic [7:0] event_q;

    // Count LOCKED->UNLOCKED grants, saturating at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_q <= '0;
        end else if ((state_q == S_LOCKED) && (state_d == S_UNLOCKED) && (event_q != '1)) begin
            event_q <= event_q + 8'd1;
        end
    end

    assign bus.event_count = event_q;
`else
    assign bus.event_count = '0;
`endif

    assign bus.solenoid_en = sol_q;
    assign bus.state_o     = state_q;
    assign bus.alarm       = alarm_q;
    assign bus.tamper      = tamper_q;

endmodule

// File: tb/tb_door_lock_actuator.sv
// Self-checking bench for door_lock_actuator (default parameters 20/50/4).
`timescale 1ns/1ps
module tb_door_lock_actuator;

    logic clk = 1'b0;
    logic reset;

    door_lock_actuator_if bus_if();

    door_lock_actuator #(
        .UNLOCK_CYCLES(20),
        .HOLD_CYCLES(50),
        .SETTLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int grants = 0;

    typedef struct {
        string       name;
        logic        req;
        logic        lck;
        logic        door;
        int unsigned cycles;
        logic [1:0]  st;
        logic        sol;
        logic        alm;
        logic        tmp;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] outs;
    } exp_t;

    vec_t vecs[17];
    exp_t sb_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic r, input logic l, input logic d);
        bus_if.unlock_req = r;
        bus_if.lock_cmd   = l;
        bus_if.door_open  = d;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef DOOR_EVENT_CNT_EN
        return (grants > 255) ? 32'd255 : 32'(grants);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [4:0] outs_now();
        return {bus_if.state_o, bus_if.solenoid_en, bus_if.alarm, bus_if.tamper};
    endfunction

    initial begin
        logic [1:0] prev_st;
        exp_t       e;

        // ---------------- reset ----------------
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_outs", 32'(outs_now()), 32'd0);
        chk("reset_cnt", 32'(bus_if.event_count), 32'd0);

        // ---------------- table-driven phases ----------------
        vecs[0]  = '{"grant",           1'b1, 1'b0, 1'b0,  1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"window_19",       1'b0, 1'b0, 1'b0, 19, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"timeout",         1'b0, 1'b0, 1'b0,  1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"grant2",          1'b1, 1'b0, 1'b0,  1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"wait3",           1'b0, 1'b0, 1'b0,  3, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"door_open_sync",  1'b0, 1'b0, 1'b1,  3, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"open_held",       1'b0, 1'b0, 1'b1,  5, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{"close_sync",      1'b0, 1'b0, 1'b0,  2, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"relock_enter",    1'b0, 1'b0, 1'b0,  1, 2'd3, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{"relock_settle",   1'b0, 1'b0, 1'b0,  3, 2'd3, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{"relock_done",     1'b0, 1'b0, 1'b0,  1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"grant3",          1'b1, 1'b0, 1'b0,  1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{"lock_cmd",        1'b0, 1'b1, 1'b0,  1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{"lock_in_locked",  1'b0, 1'b1, 1'b0,  2, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{"req_and_lock",    1'b1, 1'b1, 1'b0,  1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{"idle_unlocked",   1'b0, 1'b0, 1'b0,  1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{"lock_cmd2",       1'b0, 1'b1, 1'b0,  1, 2'd0, 1'b0, 1'b0, 1'b0};

        prev_st = 2'd0;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].req, vecs[i].lck, vecs[i].door);
            sb_q.push_back('{vecs[i].name, {vecs[i].st, vecs[i].sol, vecs[i].alm, vecs[i].tmp}});
            if (vecs[i].req && prev_st == 2'd0) grants++;
            prev_st = vecs[i].st;
            repeat (vecs[i].cycles) tick();
            e = sb_q.pop_front();
            chk(e.name, 32'(outs_now()), 32'(e.outs));
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("table_cnt", 32'(bus_if.event_count), exp_cnt());

        // ---------------- exact unlock timeout ----------------
        drive(1'b1, 1'b0, 1'b0);
        tick();
        grants++;
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("timeout_sol_hi", 32'(bus_if.solenoid_en), 32'd1);
            tick();
        end
        chk("timeout_state", 32'(bus_if.state_o), 32'd0);
        chk("timeout_sol_lo", 32'(bus_if.solenoid_en), 32'd0);
        chk("timeout_cnt", 32'(bus_if.event_count), exp_cnt());

        // ---------------- window extension ----------------
        drive(1'b1, 1'b0, 1'b0);
        tick();
        grants++;
        drive(1'b0, 1'b0, 1'b0);
        repeat (9) tick();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        repeat (19) tick();
        chk("extend_still_open", 32'(bus_if.state_o), 32'd1);
        tick();
        chk("extend_timeout", 32'(bus_if.state_o), 32'd0);
        chk("extend_cnt", 32'(bus_if.event_count), exp_cnt());

        // ---------------- lock_cmd at UNLOCKED cycle 3 ----------------
        drive(1'b1, 1'b0, 1'b0);
        tick();
        grants++;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        drive(1'b0, 1'b1, 1'b0);
        chk("lockcmd_before", 32'(bus_if.state_o), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("lockcmd_after", 32'({bus_if.state_o, bus_if.solenoid_en}), 32'd0);

        // ---------------- unlock beats tamper in same cycle ----------------
        drive(1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        drive(1'b1, 1'b0, 1'b1);
        tick();
        grants++;
        drive(1'b0, 1'b0, 1'b1);
        chk("simul_unlock", 32'(outs_now()), 32'({2'd1, 1'b1, 1'b0, 1'b0}));
        tick();
        chk("simul_open", 32'(outs_now()), 32'({2'd2, 1'b1, 1'b0, 1'b0}));
        drive(1'b0, 1'b0, 1'b0);
        repeat (7) tick();
        chk("simul_relocked", 32'(outs_now()), 32'd0);

        // ---------------- held open alarm ----------------
        drive(1'b1, 1'b0, 1'b0);
        tick();
        grants++;
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        chk("held_enter_open", 32'(outs_now()), 32'({2'd2, 1'b1, 1'b0, 1'b0}));
        repeat (49) tick();
        chk("held_alarm_pre", 32'(bus_if.alarm), 32'd0);
        tick();
        chk("held_alarm_on", 32'(outs_now()), 32'({2'd2, 1'b1, 1'b1, 1'b0}));
        repeat (7) tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("held_alarm_stay", 32'(bus_if.alarm), 32'd1);
        repeat (2) tick();
        chk("held_alarm_last", 32'(outs_now()), 32'({2'd2, 1'b1, 1'b1, 1'b0}));
        tick();
        chk("held_alarm_clear", 32'(outs_now()), 32'({2'd3, 1'b1, 1'b0, 1'b0}));
        repeat (4) tick();
        chk("held_relocked", 32'(outs_now()), 32'd0);

        // ---------------- relock abort ----------------
        drive(1'b1, 1'b0, 1'b0);
        tick();
        grants++;
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("abort_open", 32'(bus_if.state_o), 32'd2);
        repeat (3) tick();
        chk("abort_relock", 32'(bus_if.state_o), 32'd3);
        drive(1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        chk("abort_relock2", 32'(bus_if.state_o), 32'd3);
        tick();
        chk("abort_reopen", 32'(outs_now()), 32'({2'd2, 1'b1, 1'b0, 1'b0}));
        repeat (49) tick();
        chk("abort_alarm_pre", 32'(bus_if.alarm), 32'd0);
        tick();
        chk("abort_alarm_on", 32'(bus_if.alarm), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("abort_relock3", 32'(outs_now()), 32'({2'd3, 1'b1, 1'b0, 1'b0}));
        repeat (4) tick();
        chk("abort_locked", 32'(outs_now()), 32'd0);

        // ---------------- forced entry ----------------
        drive(1'b0, 1'b0, 1'b1);
        tick();
        chk("tamper_c1", 32'(bus_if.tamper), 32'd0);
        tick();
        chk("tamper_c2", 32'(bus_if.tamper), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("tamper_set", 32'(outs_now()), 32'({2'd0, 1'b0, 1'b0, 1'b1}));
        repeat (5) tick();
        chk("tamper_sticky", 32'(outs_now()), 32'({2'd0, 1'b0, 1'b0, 1'b1}));

        // ---------------- event counter saturation ----------------
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
            grants++;
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("sat_state", 32'(outs_now()), 32'({2'd0, 1'b0, 1'b0, 1'b1}));
        chk("sat_cnt", 32'(bus_if.event_count), exp_cnt());

        // ---------------- asynchronous reset mid-operation ----------------
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("pre_areset", 32'(outs_now()), 32'({2'd1, 1'b1, 1'b0, 1'b1}));
        #3;
        reset = 1'b1;
        #1;
        chk("areset_outs", 32'(outs_now()), 32'd0);
        chk("areset_cnt", 32'(bus_if.event_count), 32'd0);
        tick();
        reset = 1'b0;
        grants = 0;
        tick();
        chk("post_areset", 32'(outs_now()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/door_lock_actuator.md
Name: door_lock_actuator

Overview:
- Downstream consumer of the serial code-detector FSM's unlock pulse (its `roll_no_02` output).
- Drives the bolt solenoid and tracks the physical door through a synchronized contact sensor.
- Times the unlock window and the relock settle period.
- Raises a held-open alarm and a sticky tamper flag for forced entry.

Parameters:
- UNLOCK_CYCLES, 20, cycles bolt stays retracted waiting for the door to open (>=1).
- HOLD_CYCLES, 50, cycles door may stay open before alarm asserts (>=1).
- SETTLE_CYCLES, 4, cycles door must stay closed before bolt re-engages (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- unlock_req  input  1  unlock pulse from the code-detector FSM; synchronous to clk.
- lock_cmd  input  1  manual relock request; synchronous to clk.
- door_open  input  1  raw door contact (1 = open); asynchronous.
- solenoid_en  output  1  1 = bolt retracted.
- state_o  output  2  current state: LOCKED=0, UNLOCKED=1, OPEN=2, RELOCK=3.
- alarm  output  1  door held open too long.
- tamper  output  1  door opened while locked; sticky.
- event_count  output  8  granted-unlock count (see Optional Feature).

Behaviour:
- Reset (async, immediate): state=LOCKED, timer=0, sync flops=0, and all outputs 0.
- All outputs are registered and reflect the current state.
- door_open passes through a 2-flop synchronizer to give door_open_s, adding 2 cycles of latency.
- A single shared timer:
  - width = clog2(max(UNLOCK,HOLD,SETTLE)+1);
  - cleared on every state change;
  - otherwise increments, saturating at its maximum.
- LOCKED (solenoid_en=0):
  - unlock_req=1 -> UNLOCKED at the next edge, so solenoid_en=1 one cycle after the req cycle.
  - door_open_s=1 -> tamper<=1 and state stays LOCKED.
  - If unlock_req and door_open_s are both high in the same cycle, the unlock wins and tamper is not set.
- UNLOCKED (solenoid_en=1):
  - door_open_s=1 -> OPEN.
  - else lock_cmd=1 -> LOCKED.
  - else timer==UNLOCK_CYCLES-1 -> LOCKED, so the bolt is retracted for exactly UNLOCK_CYCLES cycles.
  - unlock_req while UNLOCKED restarts the timer (window extension).
- OPEN (solenoid_en=1):
  - When timer reaches HOLD_CYCLES-1, alarm<=1 and stays 1 while in OPEN.
  - door_open_s=0 -> RELOCK; alarm clears on the same edge.
  - unlock_req and lock_cmd are ignored.
- RELOCK (solenoid_en=1):
  - door_open_s=1 -> OPEN.
  - else timer==SETTLE_CYCLES-1 -> LOCKED (solenoid_en=0 from that edge).
  - lock_cmd is ignored; the settle period always completes.
- tamper clears only on reset.
- alarm is never 1 outside OPEN.
- Reset mid-operation returns to LOCKED with the bolt engaged at once, regardless of door state.
- Timer saturation prevents wrap-around if parameters are misconfigured.

Optional Feature:
- Macro: DOOR_EVENT_CNT_EN.
- Defined:
  - event_count increments by 1 on each LOCKED->UNLOCKED transition;
  - it saturates at 255 and resets to 0;
  - restarting the window from UNLOCKED does not count.
- Undefined: event_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset: assert reset 3 cycles, release -> state_o=0 and solenoid_en, alarm, tamper, event_count all 0; assert reset asynchronously between edges -> outputs drop before the next edge.
- Unlock timeout: 1-cycle unlock_req at cycle N, door closed -> solenoid_en=1 on cycles N+1..N+20, state_o=0 from N+21; event_count=1 when DOOR_EVENT_CNT_EN.
- Normal pass: unlock_req at N, door_open=1 at N+5 for 10 cycles -> state_o=2 from N+8; after door closes, 2 sync cycles then RELOCK; state_o=3 for 4 cycles, then 0 with solenoid_en=0.
- Held open: unlock, then door held open 60 cycles -> alarm=1 exactly 50 cycles after entering OPEN; alarm=0 on the edge entering RELOCK.
- Forced entry: door_open=1 for 3 cycles while LOCKED, no req -> tamper=1 from the 3rd cycle and stays 1 after the door closes; state_o stays 0; only reset clears it.
- Relock abort and lock_cmd:
  - door reopens at RELOCK cycle 2 -> back to OPEN with timer=0;
  - separately, lock_cmd at UNLOCKED cycle 3 with door closed -> LOCKED next edge, solenoid_en=0.
